// File: rtl/ram_cmd_pkg.sv
// ==== ram_cmd_pkg : opcodes, FSM state type and command packing shared by ram_cmd blocks ====
// ==== Revision 1.0 ===========================================================================
`default_nettype none

package ram_cmd_pkg;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_CMD  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RESP    = 3'd6
    } state_t;

    function automatic logic [9:0] make_cmd(input logic [1:0] op, input logic [7:0] payload);
        return {op, payload};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_cmd_timer.sv
// ==== ram_cmd_timer : read-data wait counter with timeout compare ====
// ==== Revision 1.0 ===================================================
`default_nettype none

module ram_cmd_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [8:0] LIMIT = 9'(TIMEOUT_CYCLES);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    // Expiry is flagged in the cycle whose increment would make the count reach the limit.
    assign expired = enable && (({1'b0, count} + 9'd1) == LIMIT);

endmodule

`default_nettype wire

// File: rtl/ram_cmd_master.sv
// ==== ram_cmd_master : host request to RAM command sequencer; err_cnt port with RAM_CMD_STATS_EN ====
// ==== Revision 1.0 ===================================================================================
`default_nettype none

module ram_cmd_master
    import ram_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rx_valid,
    output logic [9:0] din,
    input  logic       tx_valid,
    input  logic [7:0] dout,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err
`ifdef RAM_CMD_STATS_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    state_t     state;
    state_t     next_state;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       in_wait;
    logic       expired;
    logic       timeout_hit;

    assign in_wait     = (state == ST_RD_WAIT);
    assign timeout_hit = in_wait && !tx_valid && expired;

    ram_cmd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_wait),
        .enable (in_wait),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rx_valid   = 1'b0;
        din        = 10'h000;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state = req_wr ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: begin
                rx_valid   = 1'b1;
                din        = make_cmd(OP_WR_ADDR, addr_q);
                next_state = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                rx_valid   = 1'b1;
                din        = make_cmd(OP_WR_DATA, wdata_q);
                next_state = ST_RESP;
            end
            ST_RD_ADDR: begin
                rx_valid   = 1'b1;
                din        = make_cmd(OP_RD_ADDR, addr_q);
                next_state = ST_RD_CMD;
            end
            ST_RD_CMD: begin
                rx_valid   = 1'b1;
                din        = make_cmd(OP_RD_DATA, 8'h00);
                next_state = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (tx_valid || expired) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Response fields are non-zero only during RESP; they are cleared on the way back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            rsp_data <= 8'h00;
            rsp_err  <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                addr_q  <= req_addr;
                wdata_q <= req_wr ? req_wdata : 8'h00;
            end
            if (in_wait) begin
                if (tx_valid) begin
                    rsp_data <= dout;
                    rsp_err  <= 1'b0;
                end else if (expired) begin
                    rsp_data <= 8'h00;
                    rsp_err  <= 1'b1;
                end
            end
            if (state == ST_RESP) begin
                rsp_data <= 8'h00;
                rsp_err  <= 1'b0;
            end
        end
    end

    assign rsp_valid = (state == ST_RESP);
    assign req_ready = (state == ST_IDLE) && !rst;

`ifdef RAM_CMD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (timeout_hit && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = timeout_hit;
`endif

endmodule

`default_nettype wire
